// File: rtl/sw_pkg.sv
// Shared types and constants for the multimode stopwatch: FSM state
// encoding, the four-digit BCD time record and the per-digit limits.
package sw_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } sw_state_t;

   typedef struct packed {
      logic [3:0] min_tens;
      logic [3:0] min_ones;
      logic [3:0] sec_tens;
      logic [3:0] sec_ones;
   } bcd_time_t;

   localparam int DIGIT_MAX_ONES = 9;
   localparam int DIGIT_MAX_TENS = 5;

   // Out-of-range preset digits saturate at the digit's largest legal value.
   function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
      return (d > max) ? max : d;
   endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit with synchronous clear/load and an inc/dec step that wraps
// between 0 and MAX. carry/borrow are combinational so a chain of digits
// ripples a whole tick within one clock.
module bcd_digit_counter
   import sw_pkg::*;
#(
   parameter int MAX = DIGIT_MAX_ONES
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       clear,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       inc,
   input  logic       dec,
   output logic [3:0] value,
   output logic       carry,
   output logic       borrow
);

   localparam logic [3:0] MAX_V = 4'(MAX);

   // Digit register: clear beats load, load beats counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         value <= 4'd0;
      else if (clear)
         value <= 4'd0;
      else if (load)
         value <= load_val;
      else if (inc)
         value <= (value == MAX_V) ? 4'd0 : value + 4'd1;
      else if (dec)
         value <= (value == 4'd0) ? MAX_V : value - 4'd1;
   end

   assign carry  = inc && (value == MAX_V);
   assign borrow = dec && (value == 4'd0);

endmodule

// File: rtl/multimode_stopwatch.sv
// MM:SS stopwatch counting up or down in BCD from a one-second prescaler.
// Optional lap register enabled by defining STOPWATCH_LAP_EN; without it
// lap is ignored and lap_bcd reads 0.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | stopped, time loadable, mode sampled on start
// ST_RUN    | prescaler running, time stepping once per tick
// ST_PAUSED | halted mid-count, prescaler phase retained for resume
// ST_DONE   | count-down reached 00:00; start ignored, load/clear exit
module multimode_stopwatch
   import sw_pkg::*;
#(
   parameter int TICK_DIV     = 100000000,
   parameter int MIN_TENS_MAX = 5
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        stop,
   input  logic        clear,
   input  logic        mode,
   input  logic        load,
   input  logic [15:0] preset_bcd,
   input  logic        lap,
   output logic [15:0] time_bcd,
   output logic [15:0] lap_bcd,
   output logic        running,
   output logic        tick,
   output logic        wrap,
   output logic        expired
);

   localparam int              PRESC_W    = $clog2(TICK_DIV);
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   localparam logic [3:0]      ONES_MAX   = 4'(DIGIT_MAX_ONES);
   localparam logic [3:0]      TENS_MAX   = 4'(DIGIT_MAX_TENS);
   localparam logic [3:0]      MT_MAX     = 4'(MIN_TENS_MAX);

   sw_state_t          state, state_nxt;
   logic [PRESC_W-1:0] presc, presc_nxt;
   logic               mode_q, mode_nxt;
   logic               tick_now, expire_now, load_ok, zero_eff;
   bcd_time_t          pre_raw, pre_clamp;

   logic [3:0] so, st, mo, mt;
   logic       c0, c1, c2, c3;
   logic       b0, b1, b2, mt_borrow_unused;
   logic       step_up, step_dn;

   assign pre_raw            = preset_bcd;
   assign pre_clamp.min_tens = clamp_digit(pre_raw.min_tens, MT_MAX);
   assign pre_clamp.min_ones = clamp_digit(pre_raw.min_ones, ONES_MAX);
   assign pre_clamp.sec_tens = clamp_digit(pre_raw.sec_tens, TENS_MAX);
   assign pre_clamp.sec_ones = clamp_digit(pre_raw.sec_ones, ONES_MAX);

   assign time_bcd = {mt, mo, st, so};

   // Next state, prescaler and captured mode; clear overrides everything,
   // then stop, then start. A tick that empties a count-down wins over stop.
   always_comb begin
      state_nxt  = state;
      presc_nxt  = presc;
      mode_nxt   = mode_q;
      expire_now = 1'b0;
      load_ok    = 1'b0;
      tick_now   = (state == ST_RUN) && (presc == PRESC_LAST) && !clear;
      zero_eff   = 1'b0;
      if (clear) begin
         state_nxt = ST_IDLE;
         presc_nxt = '0;
         mode_nxt  = 1'b0;
      end else begin
         load_ok  = load && (state != ST_RUN);
         zero_eff = load_ok ? (pre_clamp == '0) : (time_bcd == 16'h0000);
         case (state)
            ST_IDLE: begin
               if (!stop && start) begin
                  mode_nxt  = mode;
                  presc_nxt = '0;
                  if (mode && zero_eff) begin
                     state_nxt  = ST_DONE;
                     expire_now = 1'b1;
                  end else begin
                     state_nxt = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               presc_nxt = tick_now ? '0 : presc + 1'b1;
               if (tick_now && mode_q && (time_bcd == 16'h0001)) begin
                  state_nxt  = ST_DONE;
                  expire_now = 1'b1;
               end else if (stop) begin
                  state_nxt = ST_PAUSED;
               end
            end
            ST_PAUSED: begin
               if (!stop && start) begin
                  if (mode_q && zero_eff) begin
                     state_nxt  = ST_DONE;
                     expire_now = 1'b1;
                  end else begin
                     state_nxt = ST_RUN;
                  end
               end
            end
            ST_DONE: begin
               if (load_ok)
                  state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // State register and registered status/pulse outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= ST_IDLE;
         presc   <= '0;
         mode_q  <= 1'b0;
         running <= 1'b0;
         tick    <= 1'b0;
         wrap    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_nxt;
         presc   <= presc_nxt;
         mode_q  <= mode_nxt;
         running <= (state_nxt == ST_RUN);
         tick    <= tick_now;
         wrap    <= c3;
         expired <= expire_now;
      end
   end

   assign step_up = tick_now && !mode_q;
   assign step_dn = tick_now &&  mode_q;

   bcd_digit_counter #(.MAX(DIGIT_MAX_ONES)) u_sec_ones (
      .clk(clk), .reset(reset), .clear(clear), .load(load_ok),
      .load_val(pre_clamp.sec_ones), .inc(step_up), .dec(step_dn),
      .value(so), .carry(c0), .borrow(b0)
   );

   bcd_digit_counter #(.MAX(DIGIT_MAX_TENS)) u_sec_tens (
      .clk(clk), .reset(reset), .clear(clear), .load(load_ok),
      .load_val(pre_clamp.sec_tens), .inc(c0), .dec(b0),
      .value(st), .carry(c1), .borrow(b1)
   );

   bcd_digit_counter #(.MAX(DIGIT_MAX_ONES)) u_min_ones (
      .clk(clk), .reset(reset), .clear(clear), .load(load_ok),
      .load_val(pre_clamp.min_ones), .inc(c1), .dec(b1),
      .value(mo), .carry(c2), .borrow(b2)
   );

   bcd_digit_counter #(.MAX(MIN_TENS_MAX)) u_min_tens (
      .clk(clk), .reset(reset), .clear(clear), .load(load_ok),
      .load_val(pre_clamp.min_tens), .inc(c2), .dec(b2),
      .value(mt), .carry(c3), .borrow(mt_borrow_unused)
   );

`ifdef STOPWATCH_LAP_EN
   // Lap capture reads the registered time, so a lap on a tick cycle
   // records the value from before that tick.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         lap_bcd <= 16'h0000;
      else if (clear)
         lap_bcd <= 16'h0000;
      else if (lap && (state != ST_IDLE))
         lap_bcd <= time_bcd;
   end
`else
   logic lap_unused;
   assign lap_unused = lap;
   assign lap_bcd    = 16'h0000;
`endif

endmodule

// File: tb/tb_multimode_stopwatch.sv
module tb_multimode_stopwatch;

   localparam int TICK_DIV = 4;
   localparam int MTM      = 5;

   logic        clk = 1'b0;
   logic        reset, start, stop, clear, mode, load, lap;
   logic [15:0] preset_bcd, time_bcd, lap_bcd;
   logic        running, tick, wrap, expired;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   multimode_stopwatch #(.TICK_DIV(TICK_DIV), .MIN_TENS_MAX(MTM)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .clear(clear),
      .mode(mode), .load(load), .preset_bcd(preset_bcd), .lap(lap),
      .time_bcd(time_bcd), .lap_bcd(lap_bcd), .running(running),
      .tick(tick), .wrap(wrap), .expired(expired)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [15:0] model_inc(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so < 9) so++;
      else begin
         so = 0;
         if (st < 5) st++;
         else begin
            st = 0;
            if (mo < 9) mo++;
            else begin
               mo = 0;
               if (mt < 4'(MTM)) mt++;
               else mt = 0;
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   function automatic logic [15:0] model_dec(input logic [15:0] t);
      logic [3:0] mt, mo, st, so;
      {mt, mo, st, so} = t;
      if (so > 0) so--;
      else begin
         so = 9;
         if (st > 0) st--;
         else begin
            st = 5;
            if (mo > 0) mo--;
            else begin
               mo = 9;
               if (mt > 0) mt--;
               else mt = 4'(MTM);
            end
         end
      end
      return {mt, mo, st, so};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic do_load(input logic [15:0] v);
      preset_bcd = v;
      load = 1'b1;
      step();
      load = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 0; stop = 0; clear = 0; mode = 0; load = 0; lap = 0;
      preset_bcd = 16'h0000;
      step();
      step();
      n_cmp++;
      if ({time_bcd, lap_bcd} !== 32'h0) begin
         n_bad++;
         $display("FAIL reset_time_lap: got %h/%h expected 0000/0000", time_bcd, lap_bcd);
      end
      n_cmp++;
      if ({running, tick, wrap, expired} !== 4'b0000) begin
         n_bad++;
         $display("FAIL reset_flags: got %b expected 0000", {running, tick, wrap, expired});
      end
      reset = 1'b0;
      step();
   endtask

   task automatic test_count_up();
      logic [15:0] t;
      int ticks, first;
      logic [31:0] e;
      t = 16'h0000;
      for (int k = 0; k < 10; k++) begin
         t = model_inc(t);
         exp_q.push_back({16'h0, t});
      end
      start = 1'b1; step(); start = 1'b0;
      ticks = 0; first = -1;
      for (int c = 1; c <= 40; c++) begin
         step();
         if (tick === 1'b1) begin
            ticks++;
            if (first < 0) first = c;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL up_extra_tick: got tick at cycle %0d expected none", c);
            end else begin
               e = exp_q.pop_front();
               if (time_bcd !== e[15:0]) begin
                  n_bad++;
                  $display("FAIL up_time: got %h expected %h", time_bcd, e[15:0]);
               end
            end
         end
      end
      exp_q.delete();
      n_cmp++;
      if (first !== TICK_DIV) begin
         n_bad++;
         $display("FAIL up_first_tick: got cycle %0d expected %0d", first, TICK_DIV);
      end
      n_cmp++;
      if (ticks !== 10) begin
         n_bad++;
         $display("FAIL up_tick_count: got %0d expected 10", ticks);
      end
      n_cmp++;
      if (time_bcd !== 16'h0010 || running !== 1'b1) begin
         n_bad++;
         $display("FAIL up_final: got %h run=%b expected 0010 run=1", time_bcd, running);
      end
   endtask

   task automatic test_wrap();
      logic [15:0] t, top_t;
      logic [31:0] e;
      int wraps;
      top_t = {4'(MTM), 4'h9, 4'h5, 4'h9};
      do_clear();
      do_load(16'h5958);
      n_cmp++;
      if (time_bcd !== 16'h5958 || running !== 1'b0) begin
         n_bad++;
         $display("FAIL wrap_load: got %h run=%b expected 5958 run=0", time_bcd, running);
      end
      t = 16'h5958;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({15'h0, (t == top_t), model_inc(t)});
         t = model_inc(t);
      end
      start = 1'b1; step(); start = 1'b0;
      wraps = 0;
      for (int c = 1; c <= 2 * TICK_DIV; c++) begin
         step();
         if (wrap === 1'b1) wraps++;
         if (tick === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({wrap, time_bcd} !== e[16:0]) begin
               n_bad++;
               $display("FAIL wrap_step: got w=%b %h expected w=%b %h", wrap, time_bcd, e[16], e[15:0]);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || wraps !== 1 || running !== 1'b1) begin
         n_bad++;
         $display("FAIL wrap_summary: got left=%0d wraps=%0d run=%b expected 0/1/1", exp_q.size(), wraps, running);
      end
      exp_q.delete();
      do_clear();
      do_load(16'h3C7B);
      n_cmp++;
      if (time_bcd !== 16'h3959) begin
         n_bad++;
         $display("FAIL clamp_a: got %h expected 3959", time_bcd);
      end
      do_load(16'hFFFF);
      n_cmp++;
      if (time_bcd !== top_t) begin
         n_bad++;
         $display("FAIL clamp_b: got %h expected %h", time_bcd, top_t);
      end
   endtask

   task automatic test_count_down();
      logic [15:0] t;
      logic [31:0] e;
      int exps, late;
      do_clear();
      mode = 1'b1;
      do_load(16'h0003);
      t = 16'h0003;
      for (int k = 0; k < 3; k++) begin
         t = model_dec(t);
         exp_q.push_back({15'h0, (t == 16'h0000), t});
      end
      start = 1'b1; step(); start = 1'b0; mode = 1'b0;
      exps = 0;
      for (int c = 1; c <= 3 * TICK_DIV; c++) begin
         step();
         if (expired === 1'b1) exps++;
         if (tick === 1'b1 && exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_cmp++;
            if ({expired, time_bcd} !== e[16:0]) begin
               n_bad++;
               $display("FAIL down_step: got x=%b %h expected x=%b %h", expired, time_bcd, e[16], e[15:0]);
            end
         end
      end
      n_cmp++;
      if (exp_q.size() != 0 || exps !== 1 || running !== 1'b0) begin
         n_bad++;
         $display("FAIL down_summary: got left=%0d exp=%0d run=%b expected 0/1/0", exp_q.size(), exps, running);
      end
      exp_q.delete();
      start = 1'b1; step(); start = 1'b0;
      late = 0;
      for (int c = 0; c < 2 * TICK_DIV; c++) begin
         step();
         if (tick === 1'b1 || running === 1'b1 || expired === 1'b1) late++;
      end
      n_cmp++;
      if (late !== 0 || time_bcd !== 16'h0000) begin
         n_bad++;
         $display("FAIL done_start_ignored: got act=%0d time=%h expected 0/0000", late, time_bcd);
      end
      do_clear();
      mode = 1'b1; start = 1'b1; step(); start = 1'b0; mode = 1'b0;
      n_cmp++;
      if (expired !== 1'b1 || running !== 1'b0) begin
         n_bad++;
         $display("FAIL down_zero_start: got x=%b run=%b expected x=1 run=0", expired, running);
      end
      step();
      n_cmp++;
      if (expired !== 1'b0) begin
         n_bad++;
         $display("FAIL expired_width: got %b expected 0", expired);
      end
   endtask

   task automatic test_start_stop();
      int bad, held, wait_exp, seen;
      do_clear();
      mode = 1'b0;
      start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
      bad = 0;
      for (int c = 0; c < 2 * TICK_DIV; c++) begin
         if (running === 1'b1 || tick === 1'b1) bad++;
         step();
      end
      n_cmp++;
      if (bad !== 0 || time_bcd !== 16'h0000) begin
         n_bad++;
         $display("FAIL start_stop_idle: got act=%0d time=%h expected 0/0000", bad, time_bcd);
      end
      start = 1'b1; step(); start = 1'b0;
      repeat (5) step();
      stop = 1'b1; step(); stop = 1'b0;
      held = 6 % TICK_DIV;
      bad = 0;
      for (int c = 0; c < 5; c++) begin
         if (running === 1'b1 || tick === 1'b1) bad++;
         step();
      end
      n_cmp++;
      if (bad !== 0 || time_bcd !== model_inc(16'h0000)) begin
         n_bad++;
         $display("FAIL paused_hold: got act=%0d time=%h expected 0/0001", bad, time_bcd);
      end
      wait_exp = TICK_DIV - held;
      start = 1'b1; step(); start = 1'b0;
      seen = -1;
      for (int c = 1; c <= TICK_DIV + 2 && seen < 0; c++) begin
         step();
         if (tick === 1'b1) seen = c;
      end
      n_cmp++;
      if (seen !== wait_exp || time_bcd !== model_inc(16'h0001)) begin
         n_bad++;
         $display("FAIL resume_phase: got tick at %0d time=%h expected %0d time=0002", seen, time_bcd, wait_exp);
      end
   endtask

   task automatic test_lap();
      logic [31:0] e;
      do_clear();
      mode = 1'b0;
      do_load(16'h0042);
      lap = 1'b1; step(); lap = 1'b0;
      n_cmp++;
      if (lap_bcd !== 16'h0000) begin
         n_bad++;
         $display("FAIL lap_idle: got %h expected 0000", lap_bcd);
      end
      do_clear();
      start = 1'b1; step(); start = 1'b0; mode = 1'b1;
      repeat (7 * TICK_DIV + TICK_DIV - 1) step();
`ifdef STOPWATCH_LAP_EN
      exp_q.push_back({16'h0, 16'h0007});
`else
      exp_q.push_back({16'h0, 16'h0000});
`endif
      lap = 1'b1; step(); lap = 1'b0; mode = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (tick !== 1'b1 || time_bcd !== 16'h0008 || lap_bcd !== e[15:0]) begin
         n_bad++;
         $display("FAIL lap_on_tick: got t=%b %h lap=%h expected t=1 0008 lap=%h", tick, time_bcd, lap_bcd, e[15:0]);
      end
      stop = 1'b1; step(); stop = 1'b0;
`ifdef STOPWATCH_LAP_EN
      exp_q.push_back({16'h0, 16'h0008});
`else
      exp_q.push_back({16'h0, 16'h0000});
`endif
      lap = 1'b1; step(); lap = 1'b0;
      e = exp_q.pop_front();
      n_cmp++;
      if (lap_bcd !== e[15:0]) begin
         n_bad++;
         $display("FAIL lap_paused: got %h expected %h", lap_bcd, e[15:0]);
      end
   endtask

   task automatic test_abort();
      int bad;
      do_clear();
      mode = 1'b0;
      do_load(16'h0124);
      start = 1'b1; step(); start = 1'b0;
      repeat (TICK_DIV - 1) step();
      lap = 1'b1; step(); lap = 1'b0;
      n_cmp++;
      if (time_bcd !== 16'h0125 || running !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_setup: got %h run=%b expected 0125 run=1", time_bcd, running);
      end
      #2 reset = 1'b1;
      #1;
      n_cmp++;
      if ({time_bcd, lap_bcd, running, tick, wrap, expired} !== 36'h0) begin
         n_bad++;
         $display("FAIL async_reset: got %h %h %b expected all zero", time_bcd, lap_bcd, {running, tick, wrap, expired});
      end
      step();
      reset = 1'b0;
      bad = 0;
      for (int c = 0; c < 3; c++) begin
         step();
         if ({running, tick, wrap, expired} !== 4'b0000) bad++;
      end
      n_cmp++;
      if (bad !== 0) begin
         n_bad++;
         $display("FAIL reset_release: got %0d active cycles expected 0", bad);
      end
      do_load(16'h0124);
      start = 1'b1; step(); start = 1'b0;
      repeat (TICK_DIV - 1) step();
      lap = 1'b1; step(); lap = 1'b0;
      clear = 1'b1;
      #1;
      n_cmp++;
      if (time_bcd !== 16'h0125 || running !== 1'b1) begin
         n_bad++;
         $display("FAIL clear_pre_edge: got %h run=%b expected 0125 run=1", time_bcd, running);
      end
      step();
      clear = 1'b0;
      n_cmp++;
      if ({time_bcd, lap_bcd, running, tick, wrap, expired} !== 36'h0) begin
         n_bad++;
         $display("FAIL clear_mid_run: got %h %h %b expected all zero", time_bcd, lap_bcd, {running, tick, wrap, expired});
      end
   endtask

   initial begin
      test_reset();
      test_count_up();
      test_wrap();
      test_count_down();
      test_start_stop();
      test_lap();
      test_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
